fp_add_issuer: RTL and testbench

- Host-side sequencer for the fixed/floating-point adder core. It owns the core's Go/Ready handshake: it drives Go and consumes Ready, where the core's controller is the responder.
- Accepts operand pairs from upstream through a valid/ready port and buffers them in a small FIFO.
- Issues one operation at a time to the core, holds operands stable while the core runs, then captures each sum into an output register with a valid/ready port.
- Sits between the datapath host (testbench or bus) and the adder core top.

---
 rtl/fp_add_issuer.sv | 149 ++++++++++++++
 tb/tb_fp_add_issuer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_issuer.sv
// Host-side issuer for the FP adder core: buffers operand pairs, drives the core's Go/Ready handshake, registers sums.
// Optional watchdog on the core handshake is enabled by defining FP_ADD_ISSUER_TIMEOUT_EN.
module fp_add_issuer #(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 255,
  localparam int W           = 1 + EXPBITS + MANTISSABITS
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [W-1:0]             InA,
  input  logic [W-1:0]             InB,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [W-1:0]             OutSum,
  output logic                     AdderGo,
  output logic [W-1:0]             AdderA,
  output logic [W-1:0]             AdderB,
  input  logic                     AdderReady,
  input  logic [W-1:0]             AdderSum,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     TimeoutErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("fp_add_issuer: DEPTH must be a power of 2 >= 2 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAITLO, WAITHI} state_t;

  state_t        state;
  logic [W-1:0]  mem_a [DEPTH];
  logic [W-1:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          tmr_hit;

  // Full-check uses the registered count only, so a same-cycle pop never makes room.
  assign InReady = !Reset && (count < CW'(DEPTH));
  assign push    = InValid && InReady;
  assign pop     = (state == IDLE) && (count != '0) && (!OutValid || OutReady);
  assign Count   = count;
  assign Busy    = (state != IDLE) || (count != '0);

  // NOTE: operand storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_a[wr_ptr] <= InA;
      mem_b[wr_ptr] <= InB;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Go is registered and high only while the FSM sits in ISSUE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      AdderGo  <= 1'b0;
      AdderA   <= '0;
      AdderB   <= '0;
      OutValid <= 1'b0;
      OutSum   <= '0;
    end else begin
      AdderGo <= 1'b0;
      if (OutValid && OutReady) OutValid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            AdderA  <= mem_a[rd_ptr];
            AdderB  <= mem_b[rd_ptr];
            AdderGo <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAITLO;
        // Waiting for Ready to drop first keeps a leftover Ready from the previous op from being captured.
        WAITLO: begin
          if (tmr_hit)          state <= IDLE;
          else if (!AdderReady) state <= WAITHI;
        end
        WAITHI: begin
          if (AdderReady) begin
            OutSum   <= AdderSum;
            OutValid <= 1'b1;
            state    <= IDLE;
          end else if (tmr_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ADD_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmr;
  logic          timeout_err;

  // A completing capture in WAITHI takes priority over an expiring timer.
  assign tmr_hit = ((state == WAITLO) || (state == WAITHI && !AdderReady))
                   && (tmr == TW'(TIMEOUT - 1));
  assign TimeoutErr = timeout_err;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)
        tmr <= '0;
      else if (state == WAITLO || state == WAITHI)
        tmr <= tmr + 1'b1;
      if (tmr_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmr_hit    = 1'b0;
  assign TimeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_issuer.sv
// Self-checking bench for fp_add_issuer: behavioural adder core, vector table, and an in-order result scoreboard.
module tb_fp_add_issuer;

  localparam int W  = 32;
  localparam int CW = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [W-1:0]  InA = '0;
  logic [W-1:0]  InB = '0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [W-1:0]  OutSum;
  logic          AdderGo;
  logic [W-1:0]  AdderA;
  logic [W-1:0]  AdderB;
  logic          AdderReady;
  logic [W-1:0]  AdderSum;
  logic          Busy;
  logic [CW-1:0] Count;
  logic          TimeoutErr;

  always #5 Clock = ~Clock;

  fp_add_issuer #(
    .EXPBITS(8), .MANTISSABITS(23), .DEPTH(4), .TIMEOUT(20)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady), .InA(InA), .InB(InB),
    .OutValid(OutValid), .OutReady(OutReady), .OutSum(OutSum),
    .AdderGo(AdderGo), .AdderA(AdderA), .AdderB(AdderB),
    .AdderReady(AdderReady), .AdderSum(AdderSum),
    .Busy(Busy), .Count(Count), .TimeoutErr(TimeoutErr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural adder core ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  bit          never_ready = 1'b0;
  int          lag_cfg = 0;
  logic        m_ready;
  logic        m_busy;
  logic [31:0] m_sum;
  logic [31:0] m_pend;
  int          m_cnt;
  int          m_lag;

  always @(posedge Clock) begin
    if (Reset) begin
      m_ready <= 1'b1;
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      m_lag   <= 0;
      m_sum   <= 32'd0;
      m_pend  <= 32'd0;
    end else if (AdderGo) begin
      m_busy <= 1'b1;
      m_cnt  <= 4;
      m_pend <= r2f(f2r(AdderA) + f2r(AdderB));
      if (lag_cfg == 0) m_ready <= 1'b0;
      else              m_lag   <= lag_cfg;
    end else begin
      if (m_lag != 0) begin
        m_lag <= m_lag - 1;
        if (m_lag == 1) m_ready <= 1'b0;
      end
      if (m_busy && !never_ready) begin
        if (m_cnt == 0) begin
          m_ready <= 1'b1;
          m_sum   <= m_pend;
          m_busy  <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign AdderReady = m_ready;
  assign AdderSum   = m_ready ? m_sum : 32'hDEADBEEF;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp = '0;
  int          go_cnt = 0;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (InValid && InReady) exp_q.push_back(cur_exp);
      if (AdderGo) go_cnt++;
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) check("sb_unexpected_result", exp_q.size(), 1);
        else                   check("sb_sum", OutSum, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t vec[10];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Called just after a clock edge; returns just after the edge that accepted the pair.
  task automatic push_one(input vec_t v);
    bit ok = 1'b0;
    InValid = 1'b1;
    InA = v.a;
    InB = v.b;
    cur_exp = v.sum;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge Clock);
      ok = InReady;
      @(posedge Clock);
      #1;
    end
    InValid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      tick(1);
      done = (exp_q.size() == 0) && !Busy && !OutValid;
    end
    check(name, done, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  n;
    int  g0;
    bit  acc;
    bit  saw_low;

    vec[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};  // 1 + 2
    vec[1] = '{32'h40A00000, 32'h3F800000, 32'h40C00000};  // 5 + 1
    vec[2] = '{32'h40400000, 32'h40800000, 32'h40E00000};  // 3 + 4
    vec[3] = '{32'h41200000, 32'h41A00000, 32'h41F00000};  // 10 + 20
    vec[4] = '{32'hBF800000, 32'h40000000, 32'h3F800000};  // -1 + 2
    vec[5] = '{32'h3F000000, 32'h3F000000, 32'h3F800000};  // 0.5 + 0.5
    vec[6] = '{32'h42C80000, 32'hC2480000, 32'h42480000};  // 100 - 50
    vec[7] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000};  // 1.5 + 1.5
    vec[8] = '{32'hC0400000, 32'hC0800000, 32'hC0E00000};  // -3 + -4
    vec[9] = '{32'h44800000, 32'h3F800000, 32'h44802000};  // 1024 + 1

    // Reset state
    tick(2);
    check("in_ready_in_reset", InReady, 0);
    Reset = 1'b0;
    tick(1);
    check("rst_in_ready", InReady, 1);
    check("rst_out_valid", OutValid, 0);
    check("rst_out_sum", OutSum, 0);
    check("rst_go", AdderGo, 0);
    check("rst_adder_a", AdderA, 0);
    check("rst_adder_b", AdderB, 0);
    check("rst_count", Count, 0);
    check("rst_busy", Busy, 0);
    check("rst_timeout_err", TimeoutErr, 0);

    // Single op: Go timing and latency
    push_one(vec[0]);
    check("single_go_not_yet", AdderGo, 0);
    check("single_count_after_push", Count, 1);
    tick(1);
    check("single_go_high", AdderGo, 1);
    check("single_adder_a", AdderA, vec[0].a);
    check("single_adder_b", AdderB, vec[0].b);
    check("single_count_after_pop", Count, 0);
    check("single_busy", Busy, 1);
    tick(1);
    check("single_go_one_cycle", AdderGo, 0);
    n = 1;
    while (!OutValid && n < 60) begin
      tick(1);
      n++;
    end
    check("single_latency_edges", n, 7);
    check("single_out_sum", OutSum, 32'h40400000);
    check("single_count_end", Count, 0);
    OutReady = 1'b1;
    tick(1);
    check("single_out_valid_cleared", OutValid, 0);
    check("single_out_sum_held", OutSum, 32'h40400000);
    drain("single_drain");

    // Fill with the result slot blocked, then release and wrap the pointers
    OutReady = 1'b0;
    g0 = go_cnt;
    for (int i = 0; i < 5; i++) push_one(vec[i]);
    check("fill_count_full", Count, 4);
    check("fill_in_ready_low", InReady, 0);
    InValid = 1'b1;
    InA = vec[5].a;
    InB = vec[5].b;
    cur_exp = vec[5].sum;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (InReady) acc = 1'b1;
      @(posedge Clock);
      #1;
    end
    check("fill_sixth_held_off", acc, 0);
    check("fill_single_go", go_cnt - g0, 1);
    check("fill_stalled_valid", OutValid, 1);
    check("fill_stalled_sum", OutSum, 32'h40400000);
    OutReady = 1'b1;
    @(negedge Clock);
    check("fill_push_refused_on_pop", InReady, 0);
    @(posedge Clock);
    #1;
    check("fill_count_after_pop", Count, 3);
    check("fill_go_after_release", AdderGo, 1);
    @(negedge Clock);
    check("fill_push_now_ready", InReady, 1);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    check("fill_count_refilled", Count, 4);
    for (int i = 6; i < 10; i++) push_one(vec[i]);
    drain("fill_drain");
    check("fill_total_go", go_cnt - g0, 10);

    // Stale Ready: core holds Ready high for a while after Go
    check("stale_ready_pre", AdderReady, 1);
    OutReady = 1'b0;
    lag_cfg = 3;
    push_one(vec[1]);
    saw_low = 1'b0;
    n = 0;
    while (!OutValid && n < 60) begin
      tick(1);
      n++;
      if (!AdderReady) saw_low = 1'b1;
    end
    check("stale_ready_fell_first", saw_low, 1);
    check("stale_out_valid", OutValid, 1);
    check("stale_out_sum", OutSum, 32'h40C00000);
    lag_cfg = 0;
    OutReady = 1'b1;
    drain("stale_drain");

    // Reset while waiting in WAITHI with one pair still queued
    push_one(vec[2]);
    tick(1);
    check("rstmid_go", AdderGo, 1);
    push_one(vec[3]);
    tick(1);
    check("rstmid_queued", Count, 1);
    Reset = 1'b1;
    @(negedge Clock);
    check("rstmid_in_ready", InReady, 0);
    @(posedge Clock);
    #1;
    exp_q.delete();
    check("rstmid_out_valid", OutValid, 0);
    check("rstmid_count", Count, 0);
    check("rstmid_go_low", AdderGo, 0);
    check("rstmid_adder_a", AdderA, 0);
    check("rstmid_adder_b", AdderB, 0);
    Reset = 1'b0;
    tick(1);
    check("rstmid_in_ready_after", InReady, 1);
    push_one(vec[3]);
    drain("rstmid_drain");
    check("rstmid_new_sum", OutSum, vec[3].sum);

`ifdef FP_ADD_ISSUER_TIMEOUT_EN
    // Core never answers: watchdog drops the op and flags it
    never_ready = 1'b1;
    push_one(vec[0]);
    tick(1);
    check("to_go", AdderGo, 1);
    tick(20);
    check("to_not_yet", TimeoutErr, 0);
    tick(1);
    check("to_flag", TimeoutErr, 1);
    check("to_no_valid", OutValid, 0);
    check("to_idle", Busy, 0);
    exp_q.delete();
    never_ready = 1'b0;
    push_one(vec[1]);
    drain("to_recover_drain");
    check("to_recover_sum", OutSum, vec[1].sum);
    check("to_sticky", TimeoutErr, 1);
`else
    check("no_timeout_err", TimeoutErr, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
